// File: rtl/decode_stage.sv
// ID stage of the MIPS-subset pipeline: decode, register file, branch/jump
// resolution, hazard detection and the ID/EX pipeline register.
module decode_stage #(
   parameter logic [31:0] VECTOR = 32'd64,
   parameter int unsigned NREGS  = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ex_if_stall,
   input  logic [31:0] if_id_proximopc,
   input  logic [31:0] if_id_instrucao,
   output logic        id_if_selfontepc,
   output logic [1:0]  id_if_seltipopc,
   output logic [31:0] id_if_pcimd2ext,
   output logic [31:0] id_if_rega,
   output logic [31:0] id_if_pcindex,
   input  logic        wb_id_regwrite,
   input  logic [4:0]  wb_id_regdest,
   input  logic [31:0] wb_id_data,
   output logic        id_fw_stall,
   output logic        id_ex_valid,
   output logic [31:0] id_ex_rega,
   output logic [31:0] id_ex_regb,
   output logic [31:0] id_ex_imedext,
   output logic [4:0]  id_ex_regdest,
   output logic [3:0]  id_ex_aluop,
   output logic        id_ex_alusrc,
   output logic        id_ex_memread,
   output logic        id_ex_memwrite,
   output logic        id_ex_regwrite,
   output logic        id_ex_memtoreg,
   output logic [31:0] id_ex_proximopc
);

   localparam logic [0:0] RUN    = 1'b0;
   localparam logic [0:0] SQUASH = 1'b1;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_AND   = 4'd2;
   localparam logic [3:0] ALU_OR    = 4'd3;
   localparam logic [3:0] ALU_SLT   = 4'd4;
   localparam logic [3:0] ALU_PASSB = 4'd5;

   logic [0:0]  state;
   logic [31:0] regs [NREGS];

   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd;
   logic [31:0] imedext;
   logic [31:0] rs_val, rt_val;

   logic        is_alu, is_jr, is_addi, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, illegal;
   logic [3:0]  alu_fn;
   logic        uses_rs, uses_rt, src_match, hazard_raw, redirect_cond, in_run, bubble;

   logic [4:0]  d_regdest;
   logic [3:0]  d_aluop;
   logic [31:0] d_regb;
   logic        d_alusrc, d_memread, d_memwrite, d_regwrite, d_memtoreg;

   assign opcode  = if_id_instrucao[31:26];
   assign rs      = if_id_instrucao[25:21];
   assign rt      = if_id_instrucao[20:16];
   assign rd      = if_id_instrucao[15:11];
   assign funct   = if_id_instrucao[5:0];
   assign imedext = {{16{if_id_instrucao[15]}}, if_id_instrucao[15:0]};

   // Write-through: a same-cycle writeback is visible to the reading instruction.
   assign rs_val = (rs == 5'd0) ? '0 :
                   (wb_id_regwrite && (wb_id_regdest == rs)) ? wb_id_data : regs[rs];
   assign rt_val = (rt == 5'd0) ? '0 :
                   (wb_id_regwrite && (wb_id_regdest == rt)) ? wb_id_data : regs[rt];

   always_comb begin
      is_alu  = 1'b0;
      is_jr   = 1'b0;
      is_addi = 1'b0;
      is_lw   = 1'b0;
      is_sw   = 1'b0;
      is_beq  = 1'b0;
      is_bne  = 1'b0;
      is_j    = 1'b0;
      is_jal  = 1'b0;
      illegal = 1'b0;
      alu_fn  = ALU_ADD;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADD: begin is_alu = 1'b1; alu_fn = ALU_ADD; end
               FN_SUB: begin is_alu = 1'b1; alu_fn = ALU_SUB; end
               FN_AND: begin is_alu = 1'b1; alu_fn = ALU_AND; end
               FN_OR:  begin is_alu = 1'b1; alu_fn = ALU_OR;  end
               FN_SLT: begin is_alu = 1'b1; alu_fn = ALU_SLT; end
               FN_JR:  is_jr = 1'b1;
               default: illegal = 1'b1;
            endcase
         end
         OP_J:    is_j    = 1'b1;
         OP_JAL:  is_jal  = 1'b1;
         OP_BEQ:  is_beq  = 1'b1;
         OP_BNE:  is_bne  = 1'b1;
         OP_ADDI: is_addi = 1'b1;
         OP_LW:   is_lw   = 1'b1;
         OP_SW:   is_sw   = 1'b1;
         default: illegal = 1'b1;
      endcase
   end

   assign uses_rs = is_alu | is_jr | is_addi | is_lw | is_sw | is_beq | is_bne;
   assign uses_rt = is_alu | is_sw | is_beq | is_bne;

   assign src_match = (uses_rs && (rs == id_ex_regdest)) || (uses_rt && (rt == id_ex_regdest));
   assign hazard_raw = id_ex_valid && id_ex_regwrite && (id_ex_regdest != 5'd0) && src_match &&
                       (id_ex_memread || is_beq || is_bne || is_jr);

   assign redirect_cond = (is_beq && (rs_val == rt_val)) || (is_bne && (rs_val != rt_val)) ||
                          is_jr || is_j || is_jal || illegal;

   assign in_run           = (state == RUN);
   assign id_fw_stall      = !reset && in_run && hazard_raw;
   assign id_if_selfontepc = !reset && in_run && !hazard_raw && redirect_cond;
   assign id_if_seltipopc  = illegal        ? 2'b11 :
                             (is_j | is_jal) ? 2'b10 :
                             is_jr          ? 2'b01 : 2'b00;
   assign id_if_pcimd2ext  = if_id_proximopc + {imedext[29:0], 2'b00};
   assign id_if_rega       = rs_val;
   assign id_if_pcindex    = {if_id_proximopc[31:28], if_id_instrucao[25:0], 2'b00};

   always_comb begin
      d_regdest  = 5'd0;
      d_aluop    = ALU_ADD;
      d_regb     = rt_val;
      d_alusrc   = is_addi | is_lw | is_sw;
      d_memread  = is_lw;
      d_memwrite = is_sw;
      d_memtoreg = is_lw;
      d_regwrite = is_alu | is_addi | is_lw | is_jal;
      if (is_alu) begin
         d_regdest = rd;
         d_aluop   = alu_fn;
      end else if (is_addi || is_lw) begin
         d_regdest = rt;
      end else if (is_jal) begin
         d_regdest = 5'd31;
         d_aluop   = ALU_PASSB;
         d_regb    = if_id_proximopc;
      end else if (is_beq || is_bne) begin
         d_aluop   = ALU_SUB;
      end
   end

   assign bubble = !in_run || hazard_raw || illegal || is_j;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= RUN;
      end else begin
         case (state)
            RUN:     if (id_if_selfontepc && !ex_if_stall) state <= SQUASH;
            SQUASH:  if (!ex_if_stall) state <= RUN;
            default: state <= RUN;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wb_id_regwrite && (wb_id_regdest != 5'd0)) begin
         regs[wb_id_regdest] <= wb_id_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset || (!ex_if_stall && bubble)) begin
         id_ex_valid     <= 1'b0;
         id_ex_rega      <= '0;
         id_ex_regb      <= '0;
         id_ex_imedext   <= '0;
         id_ex_regdest   <= '0;
         id_ex_aluop     <= '0;
         id_ex_alusrc    <= 1'b0;
         id_ex_memread   <= 1'b0;
         id_ex_memwrite  <= 1'b0;
         id_ex_regwrite  <= 1'b0;
         id_ex_memtoreg  <= 1'b0;
         id_ex_proximopc <= '0;
      end else if (!ex_if_stall) begin
         id_ex_valid     <= 1'b1;
         id_ex_rega      <= rs_val;
         id_ex_regb      <= d_regb;
         id_ex_imedext   <= imedext;
         id_ex_regdest   <= d_regdest;
         id_ex_aluop     <= d_aluop;
         id_ex_alusrc    <= d_alusrc;
         id_ex_memread   <= d_memread;
         id_ex_memwrite  <= d_memwrite;
         id_ex_regwrite  <= d_regwrite;
         id_ex_memtoreg  <= d_memtoreg;
         id_ex_proximopc <= if_id_proximopc;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a behavioural model.
module tb_decode_stage;

   typedef struct packed {
      logic        valid;
      logic [31:0] rega;
      logic [31:0] regb;
      logic [31:0] imm;
      logic [4:0]  dest;
      logic [3:0]  aluop;
      logic        alusrc;
      logic        mr;
      logic        mw;
      logic        rw;
      logic        m2r;
      logic [31:0] pc;
   } idex_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        wen;
      logic [4:0]  wd;
      logic [31:0] wdata;
      logic        sel;
      logic [1:0]  tipo;
      idex_t       ix;
   } vec_t;

   typedef enum int {K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_JR, K_ADDI, K_LW, K_SW,
                     K_BEQ, K_BNE, K_J, K_JAL, K_ILL} kind_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        ex_if_stall = 1'b0;
   logic [31:0] if_id_proximopc = '0;
   logic [31:0] if_id_instrucao = '0;
   logic        wb_id_regwrite = 1'b0;
   logic [4:0]  wb_id_regdest = '0;
   logic [31:0] wb_id_data = '0;
   logic        id_if_selfontepc, id_fw_stall;
   logic [1:0]  id_if_seltipopc;
   logic [31:0] id_if_pcimd2ext, id_if_rega, id_if_pcindex;
   logic        id_ex_valid, id_ex_alusrc, id_ex_memread, id_ex_memwrite, id_ex_regwrite, id_ex_memtoreg;
   logic [31:0] id_ex_rega, id_ex_regb, id_ex_imedext, id_ex_proximopc;
   logic [4:0]  id_ex_regdest;
   logic [3:0]  id_ex_aluop;
   idex_t       dut_ix;

   int total = 0;
   int bad = 0;

   decode_stage #(.VECTOR(32'd64), .NREGS(32)) dut (
      .clock(clock), .reset(reset), .ex_if_stall(ex_if_stall),
      .if_id_proximopc(if_id_proximopc), .if_id_instrucao(if_id_instrucao),
      .id_if_selfontepc(id_if_selfontepc), .id_if_seltipopc(id_if_seltipopc),
      .id_if_pcimd2ext(id_if_pcimd2ext), .id_if_rega(id_if_rega), .id_if_pcindex(id_if_pcindex),
      .wb_id_regwrite(wb_id_regwrite), .wb_id_regdest(wb_id_regdest), .wb_id_data(wb_id_data),
      .id_fw_stall(id_fw_stall), .id_ex_valid(id_ex_valid),
      .id_ex_rega(id_ex_rega), .id_ex_regb(id_ex_regb), .id_ex_imedext(id_ex_imedext),
      .id_ex_regdest(id_ex_regdest), .id_ex_aluop(id_ex_aluop), .id_ex_alusrc(id_ex_alusrc),
      .id_ex_memread(id_ex_memread), .id_ex_memwrite(id_ex_memwrite),
      .id_ex_regwrite(id_ex_regwrite), .id_ex_memtoreg(id_ex_memtoreg),
      .id_ex_proximopc(id_ex_proximopc)
   );

   always #5 clock = ~clock;

   assign dut_ix = {id_ex_valid, id_ex_rega, id_ex_regb, id_ex_imedext, id_ex_regdest, id_ex_aluop,
                    id_ex_alusrc, id_ex_memread, id_ex_memwrite, id_ex_regwrite, id_ex_memtoreg,
                    id_ex_proximopc};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_ix(input string name, input idex_t exp);
      total++;
      if (dut_ix !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, dut_ix, exp, $time);
      end
   endtask

   function automatic idex_t mk(input logic v, input logic [31:0] ra, input logic [31:0] rb,
                                input logic [31:0] im, input logic [4:0] d, input logic [3:0] op,
                                input logic src, input logic mr, input logic mw, input logic rw,
                                input logic m2r, input logic [31:0] pc);
      idex_t r;
      r.valid = v; r.rega = ra; r.regb = rb; r.imm = im; r.dest = d; r.aluop = op;
      r.alusrc = src; r.mr = mr; r.mw = mw; r.rw = rw; r.m2r = m2r; r.pc = pc;
      return r;
   endfunction

   task automatic set_in(input logic [31:0] instr, input logic [31:0] pc, input logic wen,
                         input logic [4:0] wd, input logic [31:0] wdata, input logic stall);
      if_id_instrucao = instr;
      if_id_proximopc = pc;
      wb_id_regwrite  = wen;
      wb_id_regdest   = wd;
      wb_id_data      = wdata;
      ex_if_stall     = stall;
   endtask

   task automatic mid();
      @(negedge clock); #1;
   endtask

   task automatic tick();
      @(posedge clock); #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      set_in(32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
      tick();
      reset = 1'b0;
   endtask

   function automatic logic [31:0] exp_branch_tgt(input logic [31:0] pc, input logic [31:0] instr);
      logic [15:0] off = instr[15:0];
      return pc + 32'($signed(off)) * 32'd4;
   endfunction

   function automatic logic [31:0] exp_jump_tgt(input logic [31:0] pc, input logic [31:0] instr);
      return (pc & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) << 2);
   endfunction

   // ---------------- behavioural reference model ----------------
   logic [31:0] mregs [32];
   idex_t       mix;
   bit          msq;
   bit          e_sel, e_haz, e_nsq;
   logic [1:0]  e_tipo;
   logic [31:0] e_rsv;
   idex_t       e_nix;

   function automatic kind_t classify(input logic [31:0] instr);
      logic [5:0] op = instr[31:26];
      logic [5:0] fn = instr[5:0];
      if (op == 6'h00) begin
         case (fn)
            6'h20: return K_ADD;
            6'h22: return K_SUB;
            6'h24: return K_AND;
            6'h25: return K_OR;
            6'h2A: return K_SLT;
            6'h08: return K_JR;
            default: return K_ILL;
         endcase
      end
      case (op)
         6'h02: return K_J;
         6'h03: return K_JAL;
         6'h04: return K_BEQ;
         6'h05: return K_BNE;
         6'h08: return K_ADDI;
         6'h23: return K_LW;
         6'h2B: return K_SW;
         default: return K_ILL;
      endcase
   endfunction

   function automatic logic [31:0] readm(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
      if (wb_id_regwrite && wb_id_regdest == idx) return wb_id_data;
      return mregs[idx];
   endfunction

   task automatic model_eval();
      kind_t       k = classify(if_id_instrucao);
      logic [4:0]  rs = if_id_instrucao[25:21];
      logic [4:0]  rt = if_id_instrucao[20:16];
      logic [31:0] rtv = readm(rt);
      bit          alu = k inside {K_ADD, K_SUB, K_AND, K_OR, K_SLT};
      bit          use_rs = alu || (k inside {K_JR, K_ADDI, K_LW, K_SW, K_BEQ, K_BNE});
      bit          use_rt = alu || (k inside {K_SW, K_BEQ, K_BNE});
      bit          redir;
      idex_t       f;
      e_rsv = readm(rs);
      e_haz = !msq && mix.valid && mix.rw && mix.dest != 0 &&
              ((use_rs && rs == mix.dest) || (use_rt && rt == mix.dest)) &&
              (mix.mr || (k inside {K_BEQ, K_BNE, K_JR}));
      redir = (k == K_BEQ && e_rsv == rtv) || (k == K_BNE && e_rsv != rtv) ||
              (k inside {K_JR, K_J, K_JAL, K_ILL});
      e_sel  = !msq && !e_haz && redir;
      e_tipo = (k == K_ILL) ? 2'd3 : (k inside {K_J, K_JAL}) ? 2'd2 : (k == K_JR) ? 2'd1 : 2'd0;
      f = '0;
      f.valid = 1'b1;
      f.rega  = e_rsv;
      f.regb  = (k == K_JAL) ? if_id_proximopc : rtv;
      f.imm   = 32'($signed(if_id_instrucao[15:0]));
      f.pc    = if_id_proximopc;
      f.dest  = alu ? if_id_instrucao[15:11] : (k inside {K_ADDI, K_LW}) ? rt : (k == K_JAL) ? 5'd31 : 5'd0;
      f.rw    = alu || (k inside {K_ADDI, K_LW, K_JAL});
      f.aluop = alu ? 4'(int'(k)) : (k == K_JAL) ? 4'd5 : (k inside {K_BEQ, K_BNE}) ? 4'd1 : 4'd0;
      f.alusrc = k inside {K_ADDI, K_LW, K_SW};
      f.mr    = (k == K_LW);
      f.m2r   = (k == K_LW);
      f.mw    = (k == K_SW);
      if (ex_if_stall) e_nix = mix;
      else if (msq || e_haz || k == K_ILL || k == K_J) e_nix = '0;
      else e_nix = f;
      e_nsq = msq ? ex_if_stall : (e_sel && !ex_if_stall);
   endtask

   function automatic logic [31:0] make_instr(input int kind, input logic [4:0] rs, input logic [4:0] rt,
                                              input logic [4:0] rd, input logic [31:0] rnd);
      logic [31:0] base = {6'h00, rs, rt, rd, 5'd0, 6'h00};
      case (kind)
         0:  return base | 32'h20;
         1:  return base | 32'h22;
         2:  return base | 32'h24;
         3:  return base | 32'h25;
         4:  return base | 32'h2A;
         5:  return {6'h00, rs, 15'd0, 6'h08};
         6:  return {6'h08, rs, rt, rnd[15:0]};
         7:  return {6'h23, rs, rt, rnd[15:0]};
         8:  return {6'h2B, rs, rt, rnd[15:0]};
         9:  return {6'h04, rs, rt, rnd[15:0]};
         10: return {6'h05, rs, rt, rnd[15:0]};
         11: return {6'h02, rnd[25:0]};
         12: return {6'h03, rnd[25:0]};
         default: return rnd[0] ? {6'h3F, rnd[25:0]} : {6'h00, rs, rt, rd, 5'd0, 6'h21};
      endcase
   endfunction

   vec_t tbl[$];

   initial begin
      // ---------------- directed vector table ----------------
      tbl.push_back('{32'h20010005, 32'h4,        0, 0, 0,        0, 0, mk(1,0,0,5,1,0,1,0,0,1,0,32'h4)});
      tbl.push_back('{32'h10420003, 32'h10,       1, 2, 7,        1, 0, mk(1,7,7,3,0,1,0,0,0,0,0,32'h10)});
      tbl.push_back('{32'h0C000100, 32'h40000008, 0, 0, 0,        1, 2, mk(1,0,32'h40000008,32'h100,31,5,0,0,0,1,0,32'h40000008)});
      tbl.push_back('{32'hFC000000, 32'h30,       0, 0, 0,        1, 3, '0});
      tbl.push_back('{32'h00A00008, 32'h20,       1, 5, 32'h80,   1, 1, mk(1,32'h80,0,8,0,0,0,0,0,0,0,32'h20)});
      tbl.push_back('{32'h08000040, 32'h100,      0, 0, 0,        1, 2, '0});
      tbl.push_back('{32'h14200005, 32'h50,       0, 0, 0,        0, 0, mk(1,0,0,5,0,1,0,0,0,0,0,32'h50)});
      tbl.push_back('{32'h14200005, 32'h50,       1, 1, 1,        1, 0, mk(1,1,0,5,0,1,0,0,0,0,0,32'h50)});
      tbl.push_back('{32'hAC220008, 32'h60,       1, 2, 9,        0, 0, mk(1,0,9,8,0,0,1,0,1,0,0,32'h60)});
      tbl.push_back('{32'h8C03FFFC, 32'h64,       0, 0, 0,        0, 0, mk(1,0,0,32'hFFFFFFFC,3,0,1,1,0,1,1,32'h64)});
      tbl.push_back('{32'h00632020, 32'h68,       1, 3, 6,        0, 0, mk(1,6,6,32'h2020,4,0,0,0,0,1,0,32'h68)});
      tbl.push_back('{32'h0022282A, 32'h6C,       1, 2, 3,        0, 0, mk(1,0,3,32'h282A,5,4,0,0,0,1,0,32'h6C)});
      tbl.push_back('{32'h00221822, 32'h70,       0, 0, 0,        0, 0, mk(1,0,0,32'h1822,3,1,0,0,0,1,0,32'h70)});
      tbl.push_back('{32'h00221824, 32'h74,       0, 0, 0,        0, 0, mk(1,0,0,32'h1824,3,2,0,0,0,1,0,32'h74)});
      tbl.push_back('{32'h00221825, 32'h78,       0, 0, 0,        0, 0, mk(1,0,0,32'h1825,3,3,0,0,0,1,0,32'h78)});
      tbl.push_back('{32'h00000021, 32'h7C,       0, 0, 0,        1, 3, '0});
      tbl.push_back('{32'h28000000, 32'h80,       0, 0, 0,        1, 3, '0});

      do_reset();
      chk_ix("reset_idex", '0);
      reset = 1'b1;
      set_in(32'h0C000100, 32'h4, 1'b0, 5'd0, 32'h0, 1'b0);
      mid();
      chk("reset_sel", 32'(id_if_selfontepc), 32'd0);
      chk("reset_fwstall", 32'(id_fw_stall), 32'd0);
      tick();
      reset = 1'b0;

      foreach (tbl[i]) begin
         do_reset();
         set_in(tbl[i].instr, tbl[i].pc, tbl[i].wen, tbl[i].wd, tbl[i].wdata, 1'b0);
         mid();
         chk($sformatf("vec%0d_sel", i), 32'(id_if_selfontepc), 32'(tbl[i].sel));
         if (tbl[i].sel) chk($sformatf("vec%0d_tipo", i), 32'(id_if_seltipopc), 32'(tbl[i].tipo));
         chk($sformatf("vec%0d_pcimd", i), id_if_pcimd2ext, exp_branch_tgt(tbl[i].pc, tbl[i].instr));
         chk($sformatf("vec%0d_pcindex", i), id_if_pcindex, exp_jump_tgt(tbl[i].pc, tbl[i].instr));
         tick();
         chk_ix($sformatf("vec%0d_idex", i), tbl[i].ix);
      end

      // ---------------- squash after redirect, reset mid-squash ----------------
      do_reset();
      set_in(32'h10420003, 32'h10, 1'b1, 5'd2, 32'd7, 1'b0);
      mid();
      chk("sq_beq_sel", 32'(id_if_selfontepc), 32'd1);
      chk("sq_beq_tgt", id_if_pcimd2ext, 32'h1C);
      tick();
      set_in(32'h20010005, 32'h14, 1'b0, 5'd0, 32'h0, 1'b0);
      mid();
      chk("sq_sel", 32'(id_if_selfontepc), 32'd0);
      chk("sq_fwstall", 32'(id_fw_stall), 32'd0);
      tick();
      chk_ix("sq_bubble", '0);
      tick();
      chk_ix("sq_run_again", mk(1,0,0,5,1,0,1,0,0,1,0,32'h14));
      set_in(32'h08000040, 32'h18, 1'b0, 5'd0, 32'h0, 1'b0);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      mid();
      chk("sq_reset_run_sel", 32'(id_if_selfontepc), 32'd1);
      tick();

      // ---------------- load-use and branch-operand hazards ----------------
      do_reset();
      set_in(32'h8C030000, 32'h4, 1'b0, 5'd0, 32'h0, 1'b0);
      tick();
      set_in(32'h00632020, 32'h8, 1'b0, 5'd0, 32'h0, 1'b1);
      mid();
      chk("lu_stall_exstall", 32'(id_fw_stall), 32'd1);
      tick();
      chk_ix("lu_hold", mk(1,0,0,0,3,0,1,1,0,1,1,32'h4));
      ex_if_stall = 1'b0;
      mid();
      chk("lu_stall", 32'(id_fw_stall), 32'd1);
      chk("lu_sel", 32'(id_if_selfontepc), 32'd0);
      tick();
      chk_ix("lu_bubble", '0);
      set_in(32'h00632020, 32'h8, 1'b1, 5'd3, 32'h55, 1'b0);
      mid();
      chk("lu_release", 32'(id_fw_stall), 32'd0);
      tick();
      chk_ix("lu_add", mk(1,32'h55,32'h55,32'h2020,4,0,0,0,0,1,0,32'h8));
      set_in(32'h20050001, 32'hC, 1'b0, 5'd0, 32'h0, 1'b0);
      tick();
      set_in(32'h10A00001, 32'h10, 1'b0, 5'd0, 32'h0, 1'b0);
      mid();
      chk("br_haz", 32'(id_fw_stall), 32'd1);
      tick();
      set_in(32'h10A00001, 32'h10, 1'b1, 5'd5, 32'd1, 1'b0);
      mid();
      chk("br_haz_clear", 32'(id_fw_stall), 32'd0);
      chk("br_not_taken", 32'(id_if_selfontepc), 32'd0);
      tick();

      // ---------------- ex_if_stall hold and r0 write ----------------
      do_reset();
      set_in(32'h20010005, 32'h4, 1'b0, 5'd0, 32'h0, 1'b0);
      tick();
      set_in(32'h0C000100, 32'h40000008, 1'b1, 5'd0, 32'hDEAD, 1'b1);
      mid();
      chk("st_jal_sel", 32'(id_if_selfontepc), 32'd1);
      chk("st_jal_tipo", 32'(id_if_seltipopc), 32'd2);
      chk("st_jal_pcindex", id_if_pcindex, 32'h40000400);
      tick();
      chk_ix("st_hold", mk(1,0,0,5,1,0,1,0,0,1,0,32'h4));
      set_in(32'h0C000100, 32'h40000008, 1'b0, 5'd0, 32'h0, 1'b0);
      mid();
      chk("st_still_run", 32'(id_if_selfontepc), 32'd1);
      tick();
      chk_ix("st_jal", mk(1,0,32'h40000008,32'h100,31,5,0,0,0,1,0,32'h40000008));
      set_in(32'h00003020, 32'h44, 1'b0, 5'd0, 32'h0, 1'b0);
      tick();
      mid();
      chk("r0_reads_zero", id_if_rega, 32'd0);
      tick();
      chk_ix("r0_add", mk(1,0,0,32'h3020,6,0,0,0,0,1,0,32'h44));

      // ---------------- randomized traffic vs model ----------------
      do_reset();
      foreach (mregs[i]) mregs[i] = '0;
      mix = '0;
      msq = 1'b0;
      for (int n = 0; n < 600; n++) begin
         logic [31:0] rnd = $urandom;
         logic [31:0] ins = make_instr($urandom_range(0, 13), 5'($urandom_range(0, 7)),
                                      5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), rnd);
         logic [31:0] wdat = ($urandom_range(0, 2) == 0) ? 32'd0 : ($urandom_range(0, 1) ? 32'd1 : $urandom);
         reset = ($urandom_range(0, 59) == 0);
         set_in(ins, $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                wdat, ($urandom_range(0, 4) == 0));
         mid();
         if (reset) begin
            chk("rnd_reset_sel", 32'(id_if_selfontepc), 32'd0);
            chk("rnd_reset_fw", 32'(id_fw_stall), 32'd0);
         end else begin
            model_eval();
            chk("rnd_sel", 32'(id_if_selfontepc), 32'(e_sel));
            chk("rnd_fwstall", 32'(id_fw_stall), 32'(e_haz));
            if (e_sel) chk("rnd_tipo", 32'(id_if_seltipopc), 32'(e_tipo));
            chk("rnd_rega", id_if_rega, e_rsv);
            chk("rnd_pcimd", id_if_pcimd2ext, exp_branch_tgt(if_id_proximopc, if_id_instrucao));
            chk("rnd_pcindex", id_if_pcindex, exp_jump_tgt(if_id_proximopc, if_id_instrucao));
         end
         tick();
         if (reset) begin
            foreach (mregs[i]) mregs[i] = '0;
            mix = '0;
            msq = 1'b0;
         end else begin
            if (wb_id_regwrite && wb_id_regdest != 0) mregs[wb_id_regdest] = wb_id_data;
            mix = e_nix;
            msq = e_nsq;
         end
         chk_ix("rnd_idex", mix);
      end
      reset = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- ID stage of the 5-stage MIPS-subset pipeline. Sits between Fetch (IF/ID) and Execute (ID/EX).
- Decodes the instruction and owns the 32x32 register file. Resolves branches and jumps in ID and drives the PC-source controls back to Fetch.
- Detects load-use and branch-operand hazards. Registers control and operands into the ID/EX pipeline register.

Parameters:
- VECTOR, 32'd64: illegal-instruction vector. Documentation only; Fetch hard-codes this value for seltipopc 2'b11.
- NREGS, 32: register count. Register 0 is hardwired to zero.

Ports:
- clock  in  1  pipeline clock; ID/EX and regfile update on posedge.
- reset  in  1  reset, synchronous, active-high.
- ex_if_stall  in  1  Execute stall; ID/EX holds.
- if_id_proximopc  in  32  PC+4 of the instruction in ID.
- if_id_instrucao  in  32  instruction in ID.
- id_if_selfontepc  out  1  1 = redirect PC (combinational).
- id_if_seltipopc  out  2  00 branch, 01 register, 10 jump index, 11 vector.
- id_if_pcimd2ext  out  32  proximopc + (sext(imm16)<<2).
- id_if_rega  out  32  rs read value (jr target).
- id_if_pcindex  out  32  {proximopc[31:28], instr[25:0], 2'b00}.
- wb_id_regwrite  in  1  writeback enable.
- wb_id_regdest  in  5  writeback register.
- wb_id_data  in  32  writeback data.
- id_fw_stall  out  1  hazard stall request to the forwarding unit (combinational).
- id_ex_valid  out  1  ID/EX holds a real instruction.
- id_ex_rega, id_ex_regb  out  32 each  rs and rt operand values.
- id_ex_imedext  out  32  sign-extended imm16.
- id_ex_regdest  out  5  destination register.
- id_ex_aluop  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 PASSB.
- id_ex_alusrc  out  1  1 = immediate operand.
- id_ex_memread, id_ex_memwrite, id_ex_regwrite, id_ex_memtoreg  out  1 each  control bits.
- id_ex_proximopc  out  32  PC+4 passthrough.

Behaviour:
- Decoded set:
  - R-type (op 0): funct 20 add, 22 sub, 24 and, 25 or, 2A slt, 08 jr.
  - I-type: 08 addi, 23 lw, 2B sw, 04 beq, 05 bne.
  - J-type: 02 j, 03 jal.
  - All other encodings are illegal.
- Register file:
  - Writes at posedge when wb_id_regwrite=1 and wb_id_regdest!=0.
  - Reads are combinational with write-through: if the read index equals wb_id_regdest with write enabled and index!=0, return wb_id_data.
  - Register 0 always reads 0.
- Destination and ALU mapping:
  - R-type writes rd; addi and lw write rt.
  - jal writes r31 with aluop PASSB and regb = proximopc. There is no delay slot.
  - sw, beq, bne, j and jr do not write a register.
- Redirect: selfontepc=1 for any of the following, in state RUN, with no hazard:
  - beq taken (rs==rt) or bne taken (rs!=rt): seltipopc 00.
  - jr: seltipopc 01.
  - j or jal: seltipopc 10.
  - illegal instruction: seltipopc 11.
- Hazard, id_fw_stall=1 when all of the following hold:
  - id_ex_valid, id_ex_regwrite, and id_ex_regdest!=0;
  - id_ex_regdest matches a used source (rs, or rt where rt is read);
  - and either id_ex_memread=1, or the current instruction is beq/bne/jr.
  - Only the current state and instruction are used; the previous cycle's hazard status does not matter.
  - While stalled: selfontepc=0 and a bubble is loaded into ID/EX.
- FSM (posedge, two states):
  - RUN -> SQUASH when selfontepc=1 and ex_if_stall=0.
  - SQUASH -> RUN unconditionally, unless ex_if_stall=1, in which case SQUASH holds.
  - Reason: Fetch latches the sequential wrong-path instruction at the same negedge it samples the redirect. In SQUASH that instruction is ignored: bubble into ID/EX, selfontepc=0, id_fw_stall=0.
- ID/EX register:
  - ex_if_stall=1: all fields hold.
  - Else, bubble conditions (all control bits 0, valid=0): SQUASH, hazard, illegal instruction, or j.
  - Else: load the decoded fields.
  - Branches load valid=1 with no memory or register effects.
- Reset (synchronous): state=RUN; every id_ex_* output = 0; regfile cleared to 0.
  - Combinational outputs are don't-care while reset=1, except selfontepc=0 and id_fw_stall=0.
- Simultaneous events:
  - Writeback to a register read by a branch in the same cycle: the branch compares the new value.
  - Hazard together with ex_if_stall: ID/EX holds; the hazard persists and is re-evaluated next cycle.
- Reset asserted mid-SQUASH returns the FSM to RUN.

Test Plan:
- Reset, then addi r1,r0,5 (0x20010005) with proximopc=0x4 -> next posedge: valid=1, regdest=1, imedext=5, alusrc=1, regwrite=1, aluop=0.
- Write r2=7 via WB in the same cycle as beq r2,r2,+3 at proximopc=0x10 -> selfontepc=1, seltipopc=00, pcimd2ext=0x1C; next cycle in SQUASH: bubble, selfontepc=0.
- lw r3,0(r0) in EX, then add r4,r3,r3 in ID -> id_fw_stall=1, ID/EX bubble; after lw leaves EX -> stall=0, add loads rega=regb=r3.
- jal 0x100 at proximopc=0x40000008 -> seltipopc=10, pcindex=0x40000400, ID/EX regdest=31, regb=0x40000008.
- Illegal opcode 0x3F -> selfontepc=1, seltipopc=11, ID/EX bubble; jr r5 (r5=0x80) -> seltipopc=01, rega=0x80.
- ex_if_stall=1 across a new instruction -> ID/EX unchanged and FSM holds; write to r0 -> r0 still reads 0.
